// File: rtl/serial2d_pkg.sv
// rtl/serial2d_pkg.sv - shared types and precision-mode helpers for the serial 2D MAC sequencer
// Contents: mode_t (MAC precision encodings), state_t (sequencer FSM states),
// DIG_W (digit-count width), digits_a/digits_w (nibble counts per operand),
// mode_legal (true for the three supported precision encodings).
package serial2d_pkg;

    typedef enum logic [2:0] {
        MODE_8X8 = 3'b000,
        MODE_4X4 = 3'b111,
        MODE_8X4 = 3'b001
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_WAIT = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DIG_W = 3;

    function automatic logic mode_legal(input logic [2:0] md);
        return (md == MODE_8X8) || (md == MODE_4X4) || (md == MODE_8X4);
    endfunction

    // Activation nibbles: two for every mode with an 8-bit activation.
    function automatic logic [DIG_W-1:0] digits_a(input logic [2:0] md);
        logic [DIG_W-1:0] d;
        case (md)
            MODE_4X4: d = 3'd1;
            default:  d = 3'd2;
        endcase
        return d;
    endfunction

    // Weight nibbles: only the 8x8 mode carries an 8-bit weight.
    function automatic logic [DIG_W-1:0] digits_w(input logic [2:0] md);
        logic [DIG_W-1:0] d;
        case (md)
            MODE_8X8: d = 3'd2;
            default:  d = 3'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/serial2d_step_gen.sv
// rtl/serial2d_step_gen.sv - diagonal step walker producing nibble selects and step flags
// Ports:
//   clk_fast, rst_n     clock, asynchronous active-low reset
//   go                  load step 1 of a new operation on this edge
//   dig_m, dig_n        activation / weight nibble counts of the latched mode
//   a_sel, w_sel        registered nibble selects of the visible step
//   sign_ctr            visible step uses the MS weight nibble
//   shift_ctr           visible step closes a non-final diagonal
//   last                visible step is the final step of the operation
module serial2d_step_gen
    import serial2d_pkg::*;
(
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             go,
    input  logic [DIG_W-1:0] dig_m,
    input  logic [DIG_W-1:0] dig_n,
    output logic [2:0]       a_sel,
    output logic [2:0]       w_sel,
    output logic             sign_ctr,
    output logic             shift_ctr,
    output logic             last
);

    logic       active;
    logic       adv;
    logic [2:0] cur_i;
    logic [2:0] cur_j;
    logic [2:0] hi_cur;
    logic [2:0] nxt_i;
    logic [2:0] nxt_j;
    logic [2:0] hi_nxt;
    logic [2:0] last_diag;

    // The diagonal index is recovered from the selects (i = a_sel + w_sel),
    // so only the visible step is stored.
    always_comb begin
        last_diag = dig_m + dig_n - 3'd2;
        cur_i     = a_sel + w_sel;
        cur_j     = w_sel;
        hi_cur    = (cur_i < dig_n - 3'd1) ? cur_i : dig_n - 3'd1;
        if (go) begin
            nxt_i = 3'd0;
            nxt_j = 3'd0;
        end else if (cur_j < hi_cur) begin
            nxt_i = cur_i;
            nxt_j = cur_j + 3'd1;
        end else begin
            // New diagonal starts at j = max(0, i+1 - m + 1).
            nxt_i = cur_i + 3'd1;
            nxt_j = (cur_i + 3'd1 >= dig_m) ? cur_i + 3'd2 - dig_m : 3'd0;
        end
        hi_nxt = (nxt_i < dig_n - 3'd1) ? nxt_i : dig_n - 3'd1;
        adv    = go || (active && !last);
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            a_sel     <= 3'd0;
            w_sel     <= 3'd0;
            sign_ctr  <= 1'b0;
            shift_ctr <= 1'b0;
            last      <= 1'b0;
        end else if (adv) begin
            active    <= 1'b1;
            a_sel     <= nxt_i - nxt_j;
            w_sel     <= nxt_j;
            sign_ctr  <= (nxt_j == dig_n - 3'd1);
            shift_ctr <= (nxt_j == hi_nxt) && (nxt_i < last_diag);
            last      <= (nxt_j == hi_nxt) && (nxt_i == last_diag);
        end else begin
            // Between operations the step outputs rest at zero.
            active    <= 1'b0;
            a_sel     <= 3'd0;
            w_sel     <= 3'd0;
            sign_ctr  <= 1'b0;
            shift_ctr <= 1'b0;
            last      <= 1'b0;
        end
    end

endmodule

// File: rtl/serial2d_mac_ctrl.sv
// rtl/serial2d_mac_ctrl.sv - operand sequencer framing accumulation groups for the serial 2D MAC
// Optional build macro: SERIAL2D_CTRL_PREFETCH_EN adds a one-entry operand buffer
// so consecutive operations run back to back.
// Ports:
//   clk_fast, rst_n            clock, asynchronous active-low reset
//   mode, start, acc_len       group request (sampled on start in IDLE)
//   op_valid, op_ready         operand handshake; w_in/a_in the offered pair
//   w, a                       registered operands to the MAC
//   w_sel, a_sel, sign_ctr,
//   shift_ctr, rst_mult        step controls to the MAC
//   mac_rst, mode_q            accumulator reset and latched mode to the MAC
//   busy, done, mode_err       status: not idle, group finished pulse, sticky illegal-mode flag
module serial2d_mac_ctrl
    import serial2d_pkg::*;
#(
    parameter int OPS_W = 6
)
(
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [OPS_W-1:0] acc_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       w_in,
    input  logic [7:0]       a_in,
    output logic [7:0]       w,
    output logic [7:0]       a,
    output logic [2:0]       w_sel,
    output logic [2:0]       a_sel,
    output logic             sign_ctr,
    output logic             shift_ctr,
    output logic             rst_mult,
    output logic             mac_rst,
    output logic [2:0]       mode_q,
    output logic             busy,
    output logic             done,
    output logic             mode_err
);

    state_t           state;
    state_t           state_nxt;
    logic [OPS_W-1:0] ops_left;
    logic [OPS_W-1:0] ops_nxt;
    logic [2:0]       mode_nxt;
    logic             err_nxt;
    logic [7:0]       w_nxt;
    logic [7:0]       a_nxt;
    logic             ready_nxt;
    logic             handshake;
    logic             step_go;
    logic [DIG_W-1:0] dig_m;
    logic [DIG_W-1:0] dig_n;

`ifdef SERIAL2D_CTRL_PREFETCH_EN
    logic             buf_valid;
    logic [7:0]       buf_w;
    logic [7:0]       buf_a;
    logic             bufv_nxt;
    logic [7:0]       bufw_nxt;
    logic [7:0]       bufa_nxt;
`endif

    assign dig_m = digits_a(mode_q);
    assign dig_n = digits_w(mode_q);

    serial2d_step_gen u_step (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .go        (step_go),
        .dig_m     (dig_m),
        .dig_n     (dig_n),
        .a_sel     (a_sel),
        .w_sel     (w_sel),
        .sign_ctr  (sign_ctr),
        .shift_ctr (shift_ctr),
        .last      (rst_mult)
    );

    // ops_left counts operations still owed, including the one being stepped;
    // it drops on the edge that retires the final step of an operation.
    always_comb begin
        state_nxt = state;
        ops_nxt   = ops_left;
        mode_nxt  = mode_q;
        err_nxt   = mode_err;
        w_nxt     = w;
        a_nxt     = a;
        step_go   = 1'b0;
        handshake = op_valid && op_ready;
`ifdef SERIAL2D_CTRL_PREFETCH_EN
        bufv_nxt  = buf_valid;
        bufw_nxt  = buf_w;
        bufa_nxt  = buf_a;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode_legal(mode)) begin
                        mode_nxt  = mode;
                        ops_nxt   = acc_len;
                        err_nxt   = 1'b0;
                        state_nxt = ST_CLR;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                state_nxt = (ops_left == '0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (handshake) begin
                    w_nxt     = w_in;
                    a_nxt     = a_in;
                    step_go   = 1'b1;
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (rst_mult) begin
                    ops_nxt = ops_left - OPS_W'(1);
                    if (ops_left == OPS_W'(1)) begin
                        state_nxt = ST_DONE;
                    end else begin
`ifdef SERIAL2D_CTRL_PREFETCH_EN
                        if (buf_valid) begin
                            w_nxt    = buf_w;
                            a_nxt    = buf_a;
                            bufv_nxt = 1'b0;
                            step_go  = 1'b1;
                        end else if (handshake) begin
                            // Pair offered exactly on the retiring edge goes straight in.
                            w_nxt   = w_in;
                            a_nxt   = a_in;
                            step_go = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
`else
                        state_nxt = ST_WAIT;
`endif
                    end
                end
`ifdef SERIAL2D_CTRL_PREFETCH_EN
                else if (handshake) begin
                    bufv_nxt = 1'b1;
                    bufw_nxt = w_in;
                    bufa_nxt = a_in;
                end
`endif
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_WAIT);
`ifdef SERIAL2D_CTRL_PREFETCH_EN
        if ((state_nxt == ST_STEP) && !bufv_nxt && (ops_nxt > OPS_W'(1))) begin
            ready_nxt = 1'b1;
        end
`endif
    end

    // Status outputs are registered from the next-state view so they line up
    // with the state they describe.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ops_left <= '0;
            mode_q   <= 3'b000;
            mode_err <= 1'b0;
            w        <= 8'd0;
            a        <= 8'd0;
            op_ready <= 1'b0;
            mac_rst  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ops_left <= ops_nxt;
            mode_q   <= mode_nxt;
            mode_err <= err_nxt;
            w        <= w_nxt;
            a        <= a_nxt;
            op_ready <= ready_nxt;
            mac_rst  <= (state_nxt == ST_IDLE) || (state_nxt == ST_CLR);
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
        end
    end

`ifdef SERIAL2D_CTRL_PREFETCH_EN
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_w     <= 8'd0;
            buf_a     <= 8'd0;
        end else begin
            buf_valid <= bufv_nxt;
            buf_w     <= bufw_nxt;
            buf_a     <= bufa_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial2d_mac_ctrl.sv
// tb/tb_serial2d_mac_ctrl.sv - self-checking bench for serial2d_mac_ctrl
module tb_serial2d_mac_ctrl;

    localparam int OPS_W = 6;
`ifdef SERIAL2D_CTRL_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam logic [32:0] RESET_VEC = 33'h40;

    logic             clk_fast = 1'b0;
    logic             rst_n;
    logic [2:0]       mode;
    logic             start;
    logic [OPS_W-1:0] acc_len;
    logic             op_valid;
    logic             op_ready;
    logic [7:0]       w_in;
    logic [7:0]       a_in;
    logic [7:0]       w;
    logic [7:0]       a;
    logic [2:0]       w_sel;
    logic [2:0]       a_sel;
    logic             sign_ctr;
    logic             shift_ctr;
    logic             rst_mult;
    logic             mac_rst;
    logic [2:0]       mode_q;
    logic             busy;
    logic             done;
    logic             mode_err;

    always #5 clk_fast = ~clk_fast;

    serial2d_mac_ctrl #(.OPS_W(OPS_W)) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .acc_len   (acc_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .w_in      (w_in),
        .a_in      (a_in),
        .w         (w),
        .a         (a),
        .w_sel     (w_sel),
        .a_sel     (a_sel),
        .sign_ctr  (sign_ctr),
        .shift_ctr (shift_ctr),
        .rst_mult  (rst_mult),
        .mac_rst   (mac_rst),
        .mode_q    (mode_q),
        .busy      (busy),
        .done      (done),
        .mode_err  (mode_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 clear, 2 waiting, 3 stepping, 4 done.
    // The step schedule is a precomputed list walked by index k.
    int         ph;
    int         k;
    int         nst;
    int         ops;
    logic [2:0] mq;
    logic       merr;
    logic [7:0] mw;
    logic [7:0] ma;
    logic       bv;
    logic [7:0] bw;
    logic [7:0] ba;
    int         sa [4];
    int         sw [4];
    logic       ss [4];
    logic       sh [4];
    logic       sl [4];

    typedef struct {
        logic [2:0] mode;
        logic [2:0] a_sel;
        logic [2:0] w_sel;
        logic       sign;
        logic       shift;
        logic       rst;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [2:0] md);
        return (md == 3'b000) || (md == 3'b111) || (md == 3'b001);
    endfunction

    function automatic void build(input logic [2:0] md);
        int m, n, idx, lo, hi;
        m   = (md == 3'b111) ? 1 : 2;
        n   = (md == 3'b000) ? 2 : 1;
        idx = 0;
        for (int i = 0; i <= m + n - 2; i++) begin
            lo = (i - m + 1 > 0) ? i - m + 1 : 0;
            hi = (i < n - 1) ? i : n - 1;
            for (int j = lo; j <= hi; j++) begin
                sa[idx] = i - j;
                sw[idx] = j;
                ss[idx] = (j == n - 1);
                sh[idx] = (j == hi) && (i < m + n - 2);
                sl[idx] = (j == hi) && (i == m + n - 2);
                idx++;
            end
        end
        nst = idx;
    endfunction

    task automatic model_reset();
        ph = 0; k = 0; nst = 1; ops = 0; mq = 3'b000; merr = 1'b0;
        mw = 8'd0; ma = 8'd0; bv = 1'b0; bw = 8'd0; ba = 8'd0;
        for (int i = 0; i < 4; i++) begin
            sa[i] = 0; sw[i] = 0; ss[i] = 1'b0; sh[i] = 1'b0; sl[i] = 1'b0;
        end
    endtask

    function automatic logic model_ready();
        return (ph == 2) || (PF && ph == 3 && !bv && ops > 1);
    endfunction

    function automatic logic [32:0] exp_obs();
        logic [2:0] xa, xw;
        logic       xs, xh, xl;
        xa = 3'd0; xw = 3'd0; xs = 1'b0; xh = 1'b0; xl = 1'b0;
        if (ph == 3) begin
            xa = 3'(sa[k]); xw = 3'(sw[k]); xs = ss[k]; xh = sh[k]; xl = sl[k];
        end
        return {model_ready(), mw, ma, xw, xa, xs, xh, xl, (ph <= 1), mq, (ph != 0), (ph == 4), merr};
    endfunction

    function automatic logic [32:0] dut_obs();
        return {op_ready, w, a, w_sel, a_sel, sign_ctr, shift_ctr, rst_mult,
                mac_rst, mode_q, busy, done, mode_err};
    endfunction

    task automatic model_step();
        logic hs;
        hs = op_valid && model_ready();
        case (ph)
            0: if (start) begin
                if (legal(mode)) begin
                    mq = mode; ops = int'(acc_len); merr = 1'b0; build(mode); ph = 1;
                end else begin
                    merr = 1'b1;
                end
            end
            1: ph = (ops == 0) ? 4 : 2;
            2: if (hs) begin
                mw = w_in; ma = a_in; k = 0; ph = 3;
            end
            3: if (k == nst - 1) begin
                ops--;
                if (ops == 0) ph = 4;
                else if (PF && bv) begin mw = bw; ma = ba; bv = 1'b0; k = 0; end
                else if (PF && hs) begin mw = w_in; ma = a_in; k = 0; end
                else ph = 2;
            end else begin
                k++;
                if (hs) begin bw = w_in; ba = a_in; bv = 1'b1; end
            end
            default: ph = 0;
        endcase
    endtask

    // One clock: model advances with the DUT edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk_fast);
        model_step();
        @(negedge clk_fast);
        check("cycle", dut_obs(), exp_obs());
    endtask

    task automatic run_table_group(input logic [2:0] md, input logic [7:0] wv, input logic [7:0] av);
        mode = md; acc_len = 6'd1; start = 1'b1; op_valid = 1'b1; w_in = wv; a_in = av;
        tick();
        start = 1'b0;
        check("clr_mac_rst", {mac_rst, op_ready}, 2'b10);
        tick();
        check("start_to_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].mode == md) begin
                check($sformatf("tbl_row%0d", r), {a_sel, w_sel, sign_ctr, shift_ctr, rst_mult},
                      {tbl[r].a_sel, tbl[r].w_sel, tbl[r].sign, tbl[r].shift, tbl[r].rst});
                check($sformatf("tbl_operands%0d", r), {w, a}, {wv, av});
                if (!tbl[r].rst) tick();
            end
        end
        tick();
        check("done_after_rst_mult", {done, busy}, 2'b11);
        tick();
    endtask

    initial begin
        int cnt, nrst, r;

        tbl[0] = '{3'b000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3'b000, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{3'b000, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{3'b000, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{3'b001, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{3'b001, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{3'b111, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; mode = 3'b000; start = 1'b0; acc_len = '0;
        op_valid = 1'b0; w_in = 8'd0; a_in = 8'd0;
        model_reset();
        @(negedge clk_fast);
        check("reset_vec", dut_obs(), RESET_VEC);
        rst_n = 1'b1;
        tick();

        run_table_group(3'b000, 8'h9C, 8'hF3);
        run_table_group(3'b001, 8'h7E, 8'h12);
        run_table_group(3'b111, 8'hA5, 8'h5A);

        // Three 8x4 ops with op_valid held high: gap between ops depends on prefetch.
        mode = 3'b001; acc_len = 6'd3; start = 1'b1; op_valid = 1'b1;
        w_in = 8'h11; a_in = 8'h22;
        tick();
        start = 1'b0;
        cnt = 1; nrst = 0;
        while (!done && cnt < 60) begin
            w_in = 8'($urandom); a_in = 8'($urandom);
            tick();
            cnt++;
            if (rst_mult) nrst++;
        end
        check("group_cycles", cnt, PF ? 9 : 11);
        check("rst_mult_count", nrst, 3);
        op_valid = 1'b0;
        tick();

        // Illegal mode is flagged and ignored; a legal start clears the flag.
        mode = 3'b010; acc_len = 6'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_set", {mode_err, busy}, 2'b10);
        tick();
        check("err_sticky", {mode_err, busy}, 2'b10);
        mode = 3'b000; acc_len = 6'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_clear", {mode_err, busy}, 2'b01);
        op_valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) tick();
        check("legal_run_done", done, 1'b1);
        op_valid = 1'b0;
        tick();

        // Zero-length group: clear then done, never ready.
        mode = 3'b111; acc_len = 6'd0; start = 1'b1; op_valid = 1'b1;
        tick();
        start = 1'b0;
        check("len0_clr", {mac_rst, op_ready, done}, 3'b100);
        tick();
        check("len0_done", {mac_rst, op_ready, done}, 3'b001);
        tick();
        check("len0_idle", {mac_rst, busy, op_ready}, 3'b100);
        op_valid = 1'b0;

        // Asynchronous reset during step 2, then a clean restart.
        mode = 3'b000; acc_len = 6'd2; start = 1'b1; op_valid = 1'b1;
        w_in = 8'h5A; a_in = 8'h3C;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_step2", {a_sel, w_sel}, 6'b001_000);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check("async_reset_vec", dut_obs(), RESET_VEC);
        #1 rst_n = 1'b1;
        op_valid = 1'b0;
        tick();
        mode = 3'b000; acc_len = 6'd1; start = 1'b1; op_valid = 1'b1;
        w_in = 8'hC3; a_in = 8'h81;
        tick();
        start = 1'b0;
        tick();
        tick();
        op_valid = 1'b0;
        check("restart_step1", {a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, w}, {9'b000_000_010, 8'hC3});
        for (int c = 0; c < 10 && busy; c++) tick();

        // Randomized traffic: starts, modes and acc_len also change while busy.
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 9);
            if (r < 3) mode = 3'b000;
            else if (r < 6) mode = 3'b111;
            else if (r < 9) mode = 3'b001;
            else mode = 3'($urandom_range(0, 7));
            start    = ($urandom_range(0, 5) == 0);
            acc_len  = 6'($urandom_range(0, 4));
            op_valid = ($urandom_range(0, 2) != 0);
            w_in     = 8'($urandom);
            a_in     = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
